if_fetch_unit: RTL and testbench
================================

# if_fetch_unit

Instruction-fetch stage of the 554 CPU: owns the program counter, issues single-outstanding reads to instruction memory, and drives the instruction/PC pair consumed by the IF/ID pipeline register. It is the producer side of the IF/ID interface. It honours the same `stall` the IF/ID register sees, and it takes branch/jump redirects from EX. When no instruction is available, it presents a NOP (32'h0000_0000) so that IF/ID latches a bubble.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset
- PC_INC, 4, sequential PC increment
- clk  input  1  clock
- rst_n  input  1  reset: asynchronous, active-low
- stall  input  1  pipeline stall; same signal as the IF/ID register's stall
- redirect  input  1  branch/jump taken, from EX
- redirect_pc  input  32  target address; bits [1:0] forced to 0 internally
- imem_req  output  1  read request, one-cycle pulse
- imem_addr  output  32  read address, valid with imem_req
- imem_rdata  input  32  read data, valid with imem_rvalid
- imem_rvalid  input  1  read response; at least 1 cycle after the request; exactly one per request
- instruction_out  output  32  instruction to IF/ID (combinational)
- pc_out  output  32  PC of instruction_out
- if_bubble  output  1  1 when instruction_out is the inserted NOP

## Operation
- State register values: FETCH, WAIT, HOLD, DROP.
- Internal registers: pc, buf[31:0].
- **FETCH**
  - imem_req=1, imem_addr=pc; output NOP.
  - No redirect: go to WAIT.
  - redirect: pc<=redirect_pc, go to DROP. The request has already been issued.
- **WAIT**
  - !rvalid: output NOP, stay in WAIT.
  - rvalid & !stall: output imem_rdata; pc<=pc+PC_INC; go to FETCH.
  - rvalid & stall: buf<=imem_rdata; go to HOLD.
  - redirect overrides all of the above. pc<=redirect_pc, output NOP. With rvalid the response is discarded and the next state is FETCH; without rvalid the next state is DROP.
- **HOLD**
  - Output buf.
  - !stall: pc<=pc+PC_INC, go to FETCH.
  - redirect: pc<=redirect_pc, discard buf, output NOP, go to FETCH.
- **DROP**
  - Output NOP.
  - rvalid: discard the response, go to FETCH.
  - A redirect in DROP only updates pc.
- Redirect has priority over stall and rvalid in every state.
- pc_out is always equal to pc.
- if_bubble=1 whenever the output is NOP-by-insertion. It is never 1 for real data.
- PC arithmetic is 32-bit and wraps modulo 2^32 (32'hFFFF_FFFC+4 = 0).

## Timing
- Reset values:
  - state FETCH, pc=RESET_PC, buf=0.
  - imem_req=0 while rst_n is low; the first request is in the first cycle after deassertion.
  - instruction_out=0, pc_out=RESET_PC, if_bubble=1.
- With 1-cycle memory latency, an instruction is delivered every 2 cycles: request at cycle t, data at t+1, IF/ID captures at the t+1 edge.
- Redirect latency: the first request to the target occurs in the cycle after the redirect when exiting to FETCH, or 1 cycle after the dropped rvalid.
- At most one outstanding request; no imem_req outside FETCH.
- Reset mid-request: state returns to FETCH. Memory must not deliver a stale rvalid after reset (system requirement).

## Configuration
- Macro: IF_PERF_CNT_EN.
- Defined:
  - Adds output perf_fetch_cnt[31:0], incremented on each delivered instruction (WAIT&rvalid&!stall&!redirect, or HOLD&!stall&!redirect).
  - Adds output perf_wait_cnt[31:0], incremented each cycle in WAIT or DROP without a delivery.
  - Both counters reset to 0 and wrap.
- Undefined: ports and logic absent; the rest of the behaviour is identical.

## Structure
- Shared package cpu554_pkg holds:
  - NOP_INSTR = 32'h0000_0000, matching the IF/ID reset value.
  - typedef enum logic [1:0] fetch_state_t {FETCH, WAIT, HOLD, DROP}.
  - PC_W = 32.
- Sub-module fetch_perf_cnt (two counters), instantiated only under IF_PERF_CNT_EN.

## Test plan
- Reset release, 1-cycle memory returning 32'h1111_0001 then 32'h1111_0002:
  - imem_addr is 0 then 4, on imem_req pulses 2 cycles apart.
  - instruction_out shows each word in its rvalid cycle with pc_out 0 then 4.
- stall held 3 cycles starting at the rvalid of addr 8 (data 32'hABCD_0008):
  - HOLD presents 32'hABCD_0008 for all stalled cycles.
  - Next imem_addr is 12 only after stall drops.
- redirect to 32'h0000_0100 in WAIT with no rvalid (memory latency 3):
  - Late response is discarded, if_bubble stays 1.
  - Next imem_addr is 32'h100.
- redirect with redirect_pc 32'h0000_0203 coinciding with rvalid and stall:
  - Data is discarded, no HOLD entered.
  - Next imem_addr is 32'h200.
- RESET_PC=32'hFFFF_FFFC: second fetch address is 32'h0000_0000 (wrap).
- IF_PERF_CNT_EN, 4 deliveries with 1-cycle memory: perf_fetch_cnt=4 and perf_wait_cnt=0.

Source files
------------

// File: rtl/cpu554_pkg.sv
// rtl/cpu554_pkg.sv - shared types and constants for the 554 CPU fetch stage
package cpu554_pkg;

  localparam int PC_W = 32;

  // Instruction value that the IF/ID register also resets to; presented as a bubble.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2,
    DROP  = 2'd3
  } fetch_state_t;

  // Instructions are word aligned, so the low two bits of any target are ignored.
  function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] addr);
    return {addr[PC_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_perf_cnt.sv
// rtl/fetch_perf_cnt.sv - delivered-instruction and wait-cycle counters for the fetch stage
module fetch_perf_cnt
  import cpu554_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            deliver,
  input  logic            wait_cycle,
  output logic [PC_W-1:0] fetch_cnt,
  output logic [PC_W-1:0] wait_cnt
);

  // Both counters free-run and wrap; they only move on their qualifying events.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt <= '0;
      wait_cnt  <= '0;
    end else begin
      if (deliver)
        fetch_cnt <= fetch_cnt + 1'b1;
      if (wait_cycle)
        wait_cnt <= wait_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - instruction fetch stage (optional counters under IF_PERF_CNT_EN)
module if_fetch_unit
  import cpu554_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_INC   = 32'd4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_rvalid,
  output logic [31:0] instruction_out,
  output logic [31:0] pc_out,
  output logic        if_bubble
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_wait_cnt
`endif
);

  fetch_state_t    state;
  logic [PC_W-1:0] pc;
  logic [31:0]     instr_buf;

  // Fetch FSM: one outstanding read; redirect beats stall and rvalid in every state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= FETCH;
      pc        <= RESET_PC;
      instr_buf <= NOP_INSTR;
    end else begin
      case (state)
        FETCH: begin
          if (redirect) begin
            // The read to the old pc is already out; its response must be swallowed.
            pc    <= align_pc(redirect_pc);
            state <= DROP;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (redirect) begin
            pc    <= align_pc(redirect_pc);
            state <= imem_rvalid ? FETCH : DROP;
          end else if (imem_rvalid && !stall) begin
            pc    <= pc + PC_INC;
            state <= FETCH;
          end else if (imem_rvalid) begin
            instr_buf <= imem_rdata;
            state     <= HOLD;
          end
        end
        HOLD: begin
          if (redirect) begin
            pc    <= align_pc(redirect_pc);
            state <= FETCH;
          end else if (!stall) begin
            pc    <= pc + PC_INC;
            state <= FETCH;
          end
        end
        DROP: begin
          if (redirect)
            pc <= align_pc(redirect_pc);
          if (imem_rvalid)
            state <= FETCH;
        end
        default: state <= FETCH;
      endcase
    end
  end

  // Request only from FETCH, and never while reset is held.
  always_comb begin
    imem_req  = rst_n && (state == FETCH);
    imem_addr = pc;
    pc_out    = pc;
  end

  // Present real data only when it is being handed over; everything else is a bubble.
  always_comb begin
    instruction_out = NOP_INSTR;
    if_bubble       = 1'b1;
    if (!redirect) begin
      case (state)
        WAIT: begin
          if (imem_rvalid) begin
            instruction_out = imem_rdata;
            if_bubble       = 1'b0;
          end
        end
        HOLD: begin
          instruction_out = instr_buf;
          if_bubble       = 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef IF_PERF_CNT_EN
  logic deliver;
  logic wait_cycle;

  // A delivery is an instruction accepted by IF/ID; waiting is WAIT/DROP time without one.
  always_comb begin
    deliver    = !redirect && !stall &&
                 (((state == WAIT) && imem_rvalid) || (state == HOLD));
    wait_cycle = ((state == WAIT) || (state == DROP)) && !deliver;
  end

  fetch_perf_cnt u_perf (
    .clk        (clk),
    .rst_n      (rst_n),
    .deliver    (deliver),
    .wait_cycle (wait_cycle),
    .fetch_cnt  (perf_fetch_cnt),
    .wait_cnt   (perf_wait_cnt)
  );
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - directed self-checking bench for if_fetch_unit
module tb_if_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_rvalid;
  logic [31:0] instruction_out;
  logic [31:0] pc_out;
  logic        if_bubble;

  logic        req2;
  logic [31:0] addr2;
  logic        rvalid2;
  logic [31:0] instr2;
  logic [31:0] pc2;
  logic        bubble2;

`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_wait_cnt;
  logic [31:0] perf_fetch_cnt2;
  logic [31:0] perf_wait_cnt2;
`endif

  int n_total = 0;
  int n_pass  = 0;

  if_fetch_unit #(.RESET_PC(32'h0000_0000), .PC_INC(32'd4)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .stall           (stall),
    .redirect        (redirect),
    .redirect_pc     (redirect_pc),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_rdata      (imem_rdata),
    .imem_rvalid     (imem_rvalid),
    .instruction_out (instruction_out),
    .pc_out          (pc_out),
    .if_bubble       (if_bubble)
`ifdef IF_PERF_CNT_EN
    ,
    .perf_fetch_cnt  (perf_fetch_cnt),
    .perf_wait_cnt   (perf_wait_cnt)
`endif
  );

  if_fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .PC_INC(32'd4)) dut_wrap (
    .clk             (clk),
    .rst_n           (rst_n),
    .stall           (1'b0),
    .redirect        (1'b0),
    .redirect_pc     (32'h0),
    .imem_req        (req2),
    .imem_addr       (addr2),
    .imem_rdata      (32'h5555_AAAA),
    .imem_rvalid     (rvalid2),
    .instruction_out (instr2),
    .pc_out          (pc2),
    .if_bubble       (bubble2)
`ifdef IF_PERF_CNT_EN
    ,
    .perf_fetch_cnt  (perf_fetch_cnt2),
    .perf_wait_cnt   (perf_wait_cnt2)
`endif
  );

  // One-cycle memory for the wrap instance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rvalid2 <= 1'b0;
    else        rvalid2 <= req2;
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic rv, input logic [31:0] rd, input logic st,
                       input logic re, input logic [31:0] rpc);
    imem_rvalid = rv;
    imem_rdata  = rd;
    stall       = st;
    redirect    = re;
    redirect_pc = rpc;
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    #19;
    check("rst_req", {31'b0, imem_req}, 32'd0);
    check("rst_instr", instruction_out, 32'h0);
    check("rst_pc", pc_out, 32'h0);
    check("rst_bubble", {31'b0, if_bubble}, 32'd1);
    check("rst_req_wrap", {31'b0, req2}, 32'd0);
    #2 rst_n = 1'b1;
    #1;
    check("f0_req", {31'b0, imem_req}, 32'd1);
    check("f0_addr", imem_addr, 32'h0);
    check("wrap_addr0", addr2, 32'hFFFF_FFFC);

    step(); drive(1'b1, 32'h1111_0001, 1'b0, 1'b0, 32'h0);
    check("w0_instr", instruction_out, 32'h1111_0001);
    check("w0_pc", pc_out, 32'h0);
    check("w0_bubble", {31'b0, if_bubble}, 32'd0);
    check("w0_noreq", {31'b0, imem_req}, 32'd0);

    step(); drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    check("f1_req", {31'b0, imem_req}, 32'd1);
    check("f1_addr", imem_addr, 32'h4);
    check("wrap_req1", {31'b0, req2}, 32'd1);
    check("wrap_addr1", addr2, 32'h0000_0000);

    step(); drive(1'b1, 32'h1111_0002, 1'b0, 1'b0, 32'h0);
    check("w1_instr", instruction_out, 32'h1111_0002);
    check("w1_pc", pc_out, 32'h4);

    step(); drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    check("f2_addr", imem_addr, 32'h8);

    // stall held three cycles starting with the rvalid cycle
    step(); drive(1'b1, 32'hABCD_0008, 1'b1, 1'b0, 32'h0);
    check("w2_noreq", {31'b0, imem_req}, 32'd0);
    step(); drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    check("h0_instr", instruction_out, 32'hABCD_0008);
    check("h0_bubble", {31'b0, if_bubble}, 32'd0);
    check("h0_noreq", {31'b0, imem_req}, 32'd0);
    check("h0_pc", pc_out, 32'h8);
    step(); drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    check("h1_instr", instruction_out, 32'hABCD_0008);
    check("h1_noreq", {31'b0, imem_req}, 32'd0);
    step(); drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    check("h2_instr", instruction_out, 32'hABCD_0008);
    check("h2_noreq", {31'b0, imem_req}, 32'd0);
    step(); drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    check("f3_req", {31'b0, imem_req}, 32'd1);
    check("f3_addr", imem_addr, 32'hC);

    // redirect in WAIT with a 3-cycle memory
    step(); drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    check("w3_bubble", {31'b0, if_bubble}, 32'd1);
    check("w3_instr", instruction_out, 32'h0);
    step(); drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0100);
    check("w3r_bubble", {31'b0, if_bubble}, 32'd1);
    step(); drive(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0);
    check("drop_bubble", {31'b0, if_bubble}, 32'd1);
    check("drop_instr", instruction_out, 32'h0);
    check("drop_noreq", {31'b0, imem_req}, 32'd0);
    check("drop_pc", pc_out, 32'h100);
    step(); drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    check("f4_req", {31'b0, imem_req}, 32'd1);
    check("f4_addr", imem_addr, 32'h100);
    step(); drive(1'b1, 32'h2222_0100, 1'b0, 1'b0, 32'h0);
    check("w4_instr", instruction_out, 32'h2222_0100);
    check("w4_pc", pc_out, 32'h100);
    step(); drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    check("f5_addr", imem_addr, 32'h104);

    // redirect coinciding with rvalid and stall; unaligned target
    step(); drive(1'b1, 32'h3333_0104, 1'b1, 1'b1, 32'h0000_0203);
    check("w5r_bubble", {31'b0, if_bubble}, 32'd1);
    check("w5r_instr", instruction_out, 32'h0);
    step(); drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    check("f6_req", {31'b0, imem_req}, 32'd1);
    check("f6_addr", imem_addr, 32'h200);
    check("f6_bubble", {31'b0, if_bubble}, 32'd1);

    // reset in the middle of a request, then four back-to-back deliveries
    step(); drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    rst_n = 1'b0;
    #1;
    check("rst2_req", {31'b0, imem_req}, 32'd0);
    check("rst2_pc", pc_out, 32'h0);
    step();
    rst_n = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      check("seq_addr", imem_addr, 32'(i * 4));
      check("seq_req", {31'b0, imem_req}, 32'd1);
      step(); drive(1'b1, 32'hC0DE_0000 + 32'(i), 1'b0, 1'b0, 32'h0);
      check("seq_instr", instruction_out, 32'hC0DE_0000 + 32'(i));
      step(); drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    end
    check("seq_end_addr", imem_addr, 32'h10);
`ifdef IF_PERF_CNT_EN
    check("perf_fetch", perf_fetch_cnt, 32'd4);
    check("perf_wait", perf_wait_cnt, 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
